// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external single-clock dual-port RAM: port A writes, port B reads.
// Owns pointers, occupancy count, status flags and the read-valid pipeline.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 6,
  parameter int AFULL_LEVEL = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_err,
  output logic                  rd_err,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_a,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int                DEPTH_I = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = DEPTH_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AFULL = AFULL_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  unused_q_a;

  // Status is decoded from the registered count only, never from the requests.
  assign full        = (count_q == DEPTH);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AFULL);
  assign count       = count_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign ram_data_a = wr_data;
  assign ram_addr_a = wr_ptr;
  assign ram_we_a   = wr_acc & ~rst;
  assign ram_data_b = '0;
  assign ram_addr_b = rd_ptr;
  assign ram_we_b   = 1'b0;
  assign rd_data    = ram_q_b;
  assign unused_q_a = ^ram_q_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
      rd_valid <= rd_acc;
      wr_err   <= wr_en & full;
      rd_err   <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural dual-port RAM
// (registered port B read, 1-cycle latency) attached to the RAM-facing ports.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [6:0] count;
  logic       wr_err;
  logic       rd_err;
  logic [7:0] ram_data_a;
  logic [5:0] ram_addr_a;
  logic       ram_we_a;
  logic [7:0] ram_data_b;
  logic [5:0] ram_addr_b;
  logic       ram_we_b;
  logic [7:0] ram_q_a;
  logic [7:0] ram_q_b;

  logic [7:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_rptr;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .AFULL_LEVEL(60)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .wr_err(wr_err), .rd_err(rd_err),
    .ram_data_a(ram_data_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a),
    .ram_data_b(ram_data_b), .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests, then land 1 time unit after the edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    exp_rptr = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    // write request during reset must not reach the RAM
    wr_en = 1'b1; wr_data = 8'hEE;
    #1;
    check_val("we_a_in_rst", ram_we_a, 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    check_val("count_in_rst", count, 0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    check_val("rst_empty", empty, 1'b1);
    check_val("rst_full", full, 1'b0);
    check_val("rst_count", count, 0);
    check_val("rst_rd_valid", rd_valid, 1'b0);
    check_val("rst_afull", almost_full, 1'b0);
    check_val("rst_we_a", ram_we_a, 1'b0);
    check_val("rst_we_b", ram_we_b, 1'b0);
    check_val("rst_wr_err", wr_err, 1'b0);
    check_val("rst_rd_err", rd_err, 1'b0);

    // three writes then three reads
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    check_val("abc_count", count, 3);
    check_val("abc_empty", empty, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_val("rd0_valid", rd_valid, 1'b1);
    check_val("rd0_data", rd_data, 8'hAA);
    step(1'b0, 8'h00, 1'b1);
    check_val("rd1_valid", rd_valid, 1'b1);
    check_val("rd1_data", rd_data, 8'hBB);
    step(1'b0, 8'h00, 1'b1);
    check_val("rd2_valid", rd_valid, 1'b1);
    check_val("rd2_data", rd_data, 8'hCC);
    exp_rptr = exp_rptr + 6'd3;
    check_val("abc_count0", count, 0);
    check_val("abc_empty1", empty, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check_val("abc_valid_drop", rd_valid, 1'b0);

    // fill to 64
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'(i), 1'b0);
      check_val("fill_count", count, i + 1);
      check_val("fill_afull", almost_full, (i + 1 >= 60) ? 1 : 0);
      check_val("fill_full", full, (i + 1 == 64) ? 1 : 0);
    end
    wr_en = 1'b1; wr_data = 8'h77; rd_en = 1'b0;
    #1;
    check_val("ovf_we_a", ram_we_a, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    check_val("ovf_wr_err", wr_err, 1'b1);
    check_val("ovf_count", count, 64);
    step(1'b0, 8'h00, 1'b0);
    check_val("ovf_err_pulse", wr_err, 1'b0);
    check_val("ovf_count2", count, 64);

    // write+read while full: write rejected, read accepted
    step(1'b1, 8'h99, 1'b1);
    exp_rptr = exp_rptr + 6'd1;
    check_val("fr_wr_err", wr_err, 1'b1);
    check_val("fr_rd_valid", rd_valid, 1'b1);
    check_val("fr_rd_data", rd_data, 8'h00);
    check_val("fr_count", count, 63);
    check_val("fr_full", full, 1'b0);

    for (int i = 1; i < 64; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check_val("drain_data", rd_data, 8'(i));
      check_val("drain_valid", rd_valid, 1'b1);
    end
    exp_rptr = exp_rptr + 6'd63;
    check_val("drain_count", count, 0);

    // read while empty
    step(1'b0, 8'h00, 1'b1);
    check_val("emp_rd_err", rd_err, 1'b1);
    check_val("emp_rd_valid", rd_valid, 1'b0);
    check_val("emp_rptr", ram_addr_b, exp_rptr);
    check_val("emp_count", count, 0);

    // write and read together while empty: read rejected
    step(1'b1, 8'h11, 1'b1);
    check_val("ew_rd_err", rd_err, 1'b1);
    check_val("ew_rd_valid", rd_valid, 1'b0);
    check_val("ew_count", count, 1);
    // simultaneous accept at count 1
    step(1'b1, 8'h22, 1'b1);
    exp_rptr = exp_rptr + 6'd1;
    check_val("sim_count", count, 1);
    check_val("sim_data", rd_data, 8'h11);
    check_val("sim_valid", rd_valid, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    exp_rptr = exp_rptr + 6'd1;
    check_val("sim_data2", rd_data, 8'h22);
    check_val("sim_count0", count, 0);

    // wrap-around with 100 write/read pairs
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'(8'h5A + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      exp_rptr = exp_rptr + 6'd1;
      check_val("wrap_data", rd_data, 8'(8'h5A + i));
      check_val("wrap_valid", rd_valid, 1'b1);
    end
    check_val("wrap_rptr", ram_addr_b, exp_rptr);
    check_val("wrap_count", count, 0);

    // reset the cycle after an accepted read
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_val("prer_valid", rd_valid, 1'b1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    check_val("rr_valid", rd_valid, 1'b0);
    check_val("rr_count", count, 0);
    check_val("rr_empty", empty, 1'b1);
    check_val("rr_rptr", ram_addr_b, 6'd0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    check_val("post_rst_valid", rd_valid, 1'b0);
    check_val("post_rst_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
